// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared opcodes, funct3 width codes and the FSM state type
// for the memory stage.
// Optional feature macro: MEM_ALIGN_CHECK_EN (enables the misalignment helper's use).
package memory_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] FUNC_LB  = 3'b000;
    localparam logic [2:0] FUNC_LH  = 3'b001;
    localparam logic [2:0] FUNC_LW  = 3'b010;
    localparam logic [2:0] FUNC_LBU = 3'b100;
    localparam logic [2:0] FUNC_LHU = 3'b101;
    localparam logic [2:0] FUNC_SB  = 3'b000;
    localparam logic [2:0] FUNC_SH  = 3'b001;
    localparam logic [2:0] FUNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_ACCESS = 2'd1,
        M_DONE   = 2'd2
    } mstate_e;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_lane_align.sv
// mem_lane_align: combinational lane steering for the memory stage.
// Ports:
//   funct3 - access width / signedness
//   off    - byte offset within the word (addr[1:0])
//   sdata  - store data (unaligned, low bits significant)
//   rdata  - raw word from data memory
//   wdata  - store data replicated across lanes
//   wstrb  - byte-lane write strobes
//   ldata  - extracted and extended load value
module mem_lane_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ldata
);

    logic [31:0] rot;

    // Rotate so the addressed lane lands in bits [7:0]; a half access at
    // offset 3 therefore wraps to lane 0 for its upper byte.
    always_comb begin
        rot = rdata;
        case (off)
            2'd1:    rot = {rdata[7:0],  rdata[31:8]};
            2'd2:    rot = {rdata[15:0], rdata[31:16]};
            2'd3:    rot = {rdata[23:0], rdata[31:24]};
            default: rot = rdata;
        endcase
    end

    always_comb begin
        ldata = rot;
        case (funct3)
            FUNC_LB:  ldata = {{24{rot[7]}},  rot[7:0]};
            FUNC_LH:  ldata = {{16{rot[15]}}, rot[15:0]};
            FUNC_LBU: ldata = {24'h0, rot[7:0]};
            FUNC_LHU: ldata = {16'h0, rot[15:0]};
            default:  ldata = rot;
        endcase
    end

    always_comb begin
        wdata = sdata;
        wstrb = 4'b1111;
        case (funct3)
            FUNC_SB: begin
                wdata = {4{sdata[7:0]}};
                wstrb = 4'b0001 << off;
            end
            FUNC_SH: begin
                wdata = {2{sdata[15:0]}};
                wstrb = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                wdata = sdata;
                wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: fourth pipeline stage. Registers the execute result through a
// valid/allow-in handshake, performs loads/stores against a single-port data
// memory (req/ready), aligns load data and presents the write-back value.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   e_to_m_valid / m_allow_in  - upstream handshake
//   w_allow_in / m_to_w_valid  - downstream handshake; m_valid = occupied
//   e_valE, E_*                - execute-stage result and instruction fields
//   M_*                        - registered copies of the instruction fields
//   m_valW                     - write-back value
//   dmem_*                     - data memory request/response
//   m_misalign                 - misaligned access flag (MEM_ALIGN_CHECK_EN only)
// Optional feature macro: MEM_ALIGN_CHECK_EN
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int N = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          e_to_m_valid,
    output logic          m_allow_in,
    input  logic          w_allow_in,
    output logic          m_to_w_valid,
    output logic          m_valid,
    input  logic [31:0]   e_valE,
    input  logic [6:0]    E_opcode,
    input  logic [9:0]    E_funct,
    input  logic [31:0]   E_val2,
    input  logic [4:0]    E_rd,
    input  logic [N-1:0]  E_pred_history,
    output logic [6:0]    M_opcode,
    output logic [9:0]    M_funct,
    output logic [4:0]    M_rd,
    output logic [31:0]   M_valE,
    output logic [N-1:0]  M_pred_history,
    output logic [31:0]   m_valW,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [31:0]   dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic          dmem_ready,
    input  logic [31:0]   dmem_rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic          m_misalign
`endif
);

    mstate_e       state_q, state_d;
    logic          m_valid_q;
    logic [6:0]    opcode_q;
    logic [9:0]    funct_q;
    logic [4:0]    rd_q;
    logic [31:0]   valE_q;
    logic [31:0]   val2_q;
    logic [N-1:0]  hist_q;
    logic [31:0]   ldata_q;

    logic          is_load, is_store, is_mem, m_ready_go, capture;
    logic          e_is_mem, e_mis, mis;
    logic [31:0]   lane_wdata, lane_ldata;
    logic [3:0]    lane_wstrb;

    assign is_load    = (opcode_q == OP_LOAD);
    assign is_store   = (opcode_q == OP_STORE);
    assign is_mem     = m_valid_q & (is_load | is_store);
    assign m_ready_go = ~is_mem | (state_q == M_DONE);
    assign m_allow_in = ~m_valid_q | (m_ready_go & w_allow_in);
    assign capture    = m_allow_in & e_to_m_valid;
    assign e_is_mem   = is_mem_op(E_opcode);

`ifdef MEM_ALIGN_CHECK_EN
    assign e_mis      = misaligned(E_funct[2:0], e_valE[1:0]);
    assign mis        = is_mem & misaligned(funct_q[2:0], valE_q[1:0]);
    assign m_misalign = mis;
`else
    assign e_mis      = 1'b0;
    assign mis        = 1'b0;
`endif

    // IDLE and DONE share the departure logic: a captured memory op goes
    // straight to ACCESS (or DONE when it will never touch memory).
    always_comb begin
        state_d = state_q;
        case (state_q)
            M_ACCESS: if (dmem_ready) state_d = M_DONE;
            default: begin
                if (m_allow_in) begin
                    if (capture && e_is_mem) state_d = e_mis ? M_DONE : M_ACCESS;
                    else                     state_d = M_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= M_IDLE;
            m_valid_q <= 1'b0;
            ldata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (m_allow_in) m_valid_q <= e_to_m_valid;
            if (state_q == M_ACCESS && dmem_ready && is_load) ldata_q <= lane_ldata;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            opcode_q <= E_opcode;
            funct_q  <= E_funct;
            rd_q     <= E_rd;
            valE_q   <= e_valE;
            val2_q   <= E_val2;
            hist_q   <= E_pred_history;
        end
    end

    mem_lane_align u_align (
        .funct3 (funct_q[2:0]),
        .off    (valE_q[1:0]),
        .sdata  (val2_q),
        .rdata  (dmem_rdata),
        .wdata  (lane_wdata),
        .wstrb  (lane_wstrb),
        .ldata  (lane_ldata)
    );

    // Request outputs are decoded from state and the held M_* registers, so
    // they stay stable through ACCESS and drop immediately on reset.
    assign dmem_req   = (state_q == M_ACCESS);
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = {valE_q[31:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign dmem_wstrb = dmem_we ? lane_wstrb : '0;

    assign m_valid        = m_valid_q;
    assign m_to_w_valid   = m_valid_q & m_ready_go;
    assign m_valW         = mis ? '0 : (is_load ? ldata_q : valE_q);
    assign M_opcode       = opcode_q;
    assign M_funct        = funct_q;
    assign M_rd           = rd_q;
    assign M_valE         = valE_q;
    assign M_pred_history = hist_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int N = 12;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic          clk, rst;
    logic          e_to_m_valid, m_allow_in, w_allow_in, m_to_w_valid, m_valid;
    logic [31:0]   e_valE, E_val2;
    logic [6:0]    E_opcode, M_opcode;
    logic [9:0]    E_funct, M_funct;
    logic [4:0]    E_rd, M_rd;
    logic [N-1:0]  E_pred_history, M_pred_history;
    logic [31:0]   M_valE, m_valW;
    logic          dmem_req, dmem_we, dmem_ready;
    logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_wstrb;
`ifdef MEM_ALIGN_CHECK_EN
    logic          m_misalign;
`endif

    int ncomp = 0;
    int nerr  = 0;
    int acc_cnt = 0;
    int acc0;

    memory_stage #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
        .w_allow_in(w_allow_in), .m_to_w_valid(m_to_w_valid), .m_valid(m_valid),
        .e_valE(e_valE), .E_opcode(E_opcode), .E_funct(E_funct), .E_val2(E_val2),
        .E_rd(E_rd), .E_pred_history(E_pred_history),
        .M_opcode(M_opcode), .M_funct(M_funct), .M_rd(M_rd), .M_valE(M_valE),
        .M_pred_history(M_pred_history), .m_valW(m_valW),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
`ifdef MEM_ALIGN_CHECK_EN
        , .m_misalign(m_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_req && dmem_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] va, input logic [31:0] v2);
        e_to_m_valid = 1'b1;
        E_opcode     = op;
        E_funct      = {7'b0, f3};
        e_valE       = va;
        E_val2       = v2;
        E_rd         = 5'd7;
        E_pred_history = 12'h5A5;
        tick();
        e_to_m_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; e_to_m_valid = 1'b0; w_allow_in = 1'b1;
        e_valE = '0; E_opcode = '0; E_funct = '0; E_val2 = '0; E_rd = '0;
        E_pred_history = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        #3;
        check("rst_m_valid", m_valid, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_to_w_valid", m_to_w_valid, 0);
        check("rst_allow_in", m_allow_in, 1);
        @(negedge clk); rst = 1'b0;
        tick();

        // Pass-through ALU result
        issue(OP_ADD, 3'b000, 32'h1234, 32'h0);
        check("add_to_w_valid", m_to_w_valid, 1);
        check("add_valW", m_valW, 32'h1234);
        check("add_req", dmem_req, 0);
        check("add_rd", M_rd, 5'd7);
        tick();
        check("add_left", m_valid, 0);
        check("add_req2", dmem_req, 0);

        // SB at 0x103
        issue(OP_STORE, FUNC_SB, 32'h103, 32'hAB);
        check("sb_req", dmem_req, 1);
        check("sb_we", dmem_we, 1);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_wstrb", dmem_wstrb, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        check("sb_to_w_valid", m_to_w_valid, 0);
        check("sb_allow_in", m_allow_in, 0);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("sb_done_req", dmem_req, 0);
        check("sb_done_to_w", m_to_w_valid, 1);
        check("sb_done_allow", m_allow_in, 1);
        tick();
        check("sb_left", m_valid, 0);

        // SH at 0x102
        issue(OP_STORE, FUNC_SH, 32'h102, 32'h1234CDEF);
        check("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
        check("sh_wstrb", dmem_wstrb, 4'b1100);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tick();

        // SW at 0x104
        issue(OP_STORE, FUNC_SW, 32'h104, 32'hCAFEF00D);
        check("sw_wdata", dmem_wdata, 32'hCAFEF00D);
        check("sw_wstrb", dmem_wstrb, 4'b1111);
        check("sw_addr", dmem_addr, 32'h104);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tick();

        // LB / LBU at 0x102
        issue(OP_LOAD, FUNC_LB, 32'h102, 32'h0);
        check("lb_req", dmem_req, 1);
        check("lb_we", dmem_we, 0);
        check("lb_addr", dmem_addr, 32'h100);
        dmem_ready = 1'b1; dmem_rdata = 32'h00800000;
        tick();
        dmem_ready = 1'b0;
        check("lb_valW", m_valW, 32'hFFFFFF80);
        check("lb_to_w", m_to_w_valid, 1);
        tick();
        issue(OP_LOAD, FUNC_LBU, 32'h102, 32'h0);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("lbu_valW", m_valW, 32'h00000080);
        tick();

        // LW with 3 wait cycles, then downstream hold for 2 cycles
        issue(OP_LOAD, FUNC_LW, 32'h200, 32'h0);
        acc0 = acc_cnt;
        dmem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_req", dmem_req, 1);
            check("lw_wait_addr", dmem_addr, 32'h200);
            check("lw_wait_allow", m_allow_in, 0);
            tick();
        end
        check("lw_ready_req", dmem_req, 1);
        check("lw_ready_addr", dmem_addr, 32'h200);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; w_allow_in = 1'b0;
        tick();
        // ready held high while in DONE must be ignored
        dmem_rdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            check("lw_hold_req", dmem_req, 0);
            check("lw_hold_to_w", m_to_w_valid, 1);
            check("lw_hold_allow", m_allow_in, 0);
            check("lw_hold_valW", m_valW, 32'hDEADBEEF);
            tick();
        end
        dmem_ready = 1'b0; w_allow_in = 1'b1;
        #1;
        check("lw_release_allow", m_allow_in, 1);
        check("lw_valW", m_valW, 32'hDEADBEEF);
        check("lw_one_access", acc_cnt - acc0, 1);
        tick();
        check("lw_left", m_valid, 0);

        // Reset in the middle of an access
        issue(OP_LOAD, FUNC_LW, 32'h300, 32'h0);
        check("rstmid_req_before", dmem_req, 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_req", dmem_req, 0);
        check("rstmid_valid", m_valid, 0);
        check("rstmid_allow", m_allow_in, 1);
        @(negedge clk); rst = 1'b0;
        tick();
        check("rstmid_idle_req", dmem_req, 0);
        issue(OP_ADD, 3'b000, 32'h55, 32'h0);
        check("restart_valW", m_valW, 32'h55);
        check("restart_to_w", m_to_w_valid, 1);
        tick();

`ifdef MEM_ALIGN_CHECK_EN
        issue(OP_LOAD, FUNC_LW, 32'h102, 32'h0);
        check("mis_req", dmem_req, 0);
        check("mis_flag", m_misalign, 1);
        check("mis_valW", m_valW, 32'h0);
        check("mis_to_w", m_to_w_valid, 1);
        tick();
        check("mis_flag_clear", m_misalign, 0);
        check("mis_req2", dmem_req, 0);
`else
        issue(OP_LOAD, FUNC_LH, 32'h103, 32'h0);
        check("lh_wrap_req", dmem_req, 1);
        dmem_ready = 1'b1; dmem_rdata = 32'h11223344;
        tick();
        dmem_ready = 1'b0;
        check("lh_wrap_valW", m_valW, 32'h00004411);
        tick();
        check("lh_wrap_left", m_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
        $finish;
    end

endmodule
